tex_fetch_sched: RTL

- Sequences texel fetch for one dual-pixel texture request: texture word read, palette index extraction, optional CLUT read, output of two 16-bit colours.
- Shares one VRAM/texture-cache read port between texel and CLUT reads for both pixels.
- Sits between the rasterizer's UV stage and the texture blend stage.

---
 rtl/tex_fetch_sched.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/tex_fetch_sched.sv
// tex_fetch_sched: texel fetch sequencer for one dual-pixel texture request.
// Issues texel reads (and CLUT reads for 4/8-bit formats) on a single shared
// VRAM read port and presents the resulting pair of 16-bit colours.
// Optional build macro: TEX_FETCH_MERGE_EN -- skips the second texel read when
// both pixels hit the same texture word, and the second CLUT read when both
// palette indices match. Output colours are the same with or without it.
module tex_fetch_sched #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_reqValid,
    output logic              o_reqReady,
    input  logic [1:0]        i_pixMask,
    input  logic [7:0]        i_u0,
    input  logic [7:0]        i_v0,
    input  logic [7:0]        i_u1,
    input  logic [7:0]        i_v1,
    input  logic [1:0]        i_texFormat,
    input  logic [3:0]        i_texPageX,
    input  logic              i_texPageY,
    input  logic [5:0]        i_clutX,
    input  logic [8:0]        i_clutY,
    output logic              o_memReq,
    output logic [ADDR_W-1:0] o_memAddr,
    output logic              o_memIsClut,
    input  logic              i_memAck,
    input  logic [DATA_W-1:0] i_memData,
    output logic              o_outValid,
    input  logic              i_outReady,
    output logic [DATA_W-1:0] o_col0,
    output logic [DATA_W-1:0] o_col1
);

`ifdef TEX_FETCH_MERGE_EN
    localparam bit MERGE_EN = 1'b1;
`else
    localparam bit MERGE_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TEX0  = 3'd1,
        TEX1  = 3'd2,
        CLUT0 = 3'd3,
        CLUT1 = 3'd4,
        OUT   = 3'd5
    } state_e;

    // Texel halfword address: x wraps at 1024, y = page line base + v.
    function automatic logic [ADDR_W-1:0] tex_addr(
        input logic [7:0] u,
        input logic [7:0] v,
        input logic [1:0] fmt,
        input logic [3:0] page_x,
        input logic       page_y
    );
        logic [7:0] u_sh;
        logic [9:0] x;
        u_sh = u;
        case (fmt)
            2'd0:    u_sh = u >> 2;
            2'd1:    u_sh = u >> 1;
            default: u_sh = u;
        endcase
        x = {page_x, 6'd0} + {2'd0, u_sh};
        return ADDR_W'({page_y, v, x});
    endfunction

    // Palette index from a texture word: nibble u[1:0] (4-bit) or byte u[0] (8-bit).
    function automatic logic [7:0] pal_index(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        fmt,
        input logic [7:0]        u
    );
        logic [7:0] idx;
        idx = 8'd0;
        if (fmt == 2'd0) begin
            case (u[1:0])
                2'd0: idx = {4'd0, word[3:0]};
                2'd1: idx = {4'd0, word[7:4]};
                2'd2: idx = {4'd0, word[11:8]};
                2'd3: idx = {4'd0, word[15:12]};
            endcase
        end else begin
            idx = u[0] ? word[15:8] : word[7:0];
        end
        return idx;
    endfunction

    // CLUT halfword address: x = base*16 + index, wrapping at 1024.
    function automatic logic [ADDR_W-1:0] clut_addr(
        input logic [7:0] idx,
        input logic [5:0] clut_x,
        input logic [8:0] clut_y
    );
        logic [9:0] x;
        x = {clut_x, 4'd0} + {2'd0, idx};
        return ADDR_W'({clut_y, x});
    endfunction

    state_e            state_q;
    logic [1:0]        mask_q;
    logic [1:0]        fmt_q;
    logic [7:0]        u0_q, v0_q, u1_q, v1_q;
    logic [3:0]        page_x_q;
    logic              page_y_q;
    logic [5:0]        clut_x_q;
    logic [8:0]        clut_y_q;
    logic              merge_tex_q;
    logic [DATA_W-1:0] word0_q, word1_q;
    logic [DATA_W-1:0] col0_q, col1_q;
    logic              req_ready_q;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_is_clut_q;
    logic              out_valid_q;

    logic              accept_merge;
    logic              is_direct;
    logic [7:0]        idx0, idx1;

    // Both pixels enabled and pointing at the same texture word.
    assign accept_merge = MERGE_EN && (i_pixMask == 2'b11) &&
        (tex_addr(i_u0, i_v0, i_texFormat, i_texPageX, i_texPageY) ==
         tex_addr(i_u1, i_v1, i_texFormat, i_texPageX, i_texPageY));

    // Formats 2 and 3 use the texel word directly as colour.
    assign is_direct = fmt_q[1];
    assign idx0      = pal_index(word0_q, fmt_q, u0_q);
    assign idx1      = pal_index(word1_q, fmt_q, u1_q);

    // Fetch sequencer: state, latched request, captured words and registered outputs.
    // NOTE: every register here is assigned with <= so all updates use the pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            mask_q        <= '0;
            fmt_q         <= '0;
            u0_q          <= '0;
            v0_q          <= '0;
            u1_q          <= '0;
            v1_q          <= '0;
            page_x_q      <= '0;
            page_y_q      <= 1'b0;
            clut_x_q      <= '0;
            clut_y_q      <= '0;
            merge_tex_q   <= 1'b0;
            word0_q       <= '0;
            word1_q       <= '0;
            col0_q        <= '0;
            col1_q        <= '0;
            req_ready_q   <= 1'b1;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            mem_is_clut_q <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_reqValid) begin
                        mask_q      <= i_pixMask;
                        fmt_q       <= i_texFormat;
                        u0_q        <= i_u0;
                        v0_q        <= i_v0;
                        u1_q        <= i_u1;
                        v1_q        <= i_v1;
                        page_x_q    <= i_texPageX;
                        page_y_q    <= i_texPageY;
                        clut_x_q    <= i_clutX;
                        clut_y_q    <= i_clutY;
                        merge_tex_q <= accept_merge;
                        col0_q      <= '0;
                        col1_q      <= '0;
                        req_ready_q <= 1'b0;
                        if (i_pixMask == 2'b00) begin
                            state_q     <= OUT;
                            out_valid_q <= 1'b1;
                        end else if (i_pixMask == 2'b10) begin
                            state_q       <= TEX1;
                            mem_req_q     <= 1'b1;
                            mem_is_clut_q <= 1'b0;
                            mem_addr_q    <= tex_addr(i_u1, i_v1, i_texFormat, i_texPageX, i_texPageY);
                        end else begin
                            state_q       <= TEX0;
                            mem_req_q     <= 1'b1;
                            mem_is_clut_q <= 1'b0;
                            mem_addr_q    <= tex_addr(i_u0, i_v0, i_texFormat, i_texPageX, i_texPageY);
                        end
                    end
                end

                TEX0: begin
                    if (i_memAck) begin
                        word0_q <= i_memData;
                        if (is_direct) col0_q <= i_memData;
                        if (mask_q[1] && !merge_tex_q) begin
                            state_q    <= TEX1;
                            mem_addr_q <= tex_addr(u1_q, v1_q, fmt_q, page_x_q, page_y_q);
                        end else begin
                            if (merge_tex_q) begin
                                word1_q <= i_memData;
                                if (is_direct) col1_q <= i_memData;
                            end
                            if (is_direct) begin
                                state_q     <= OUT;
                                mem_req_q   <= 1'b0;
                                out_valid_q <= 1'b1;
                            end else begin
                                state_q       <= CLUT0;
                                mem_is_clut_q <= 1'b1;
                                mem_addr_q    <= clut_addr(pal_index(i_memData, fmt_q, u0_q),
                                                           clut_x_q, clut_y_q);
                            end
                        end
                    end
                end

                TEX1: begin
                    if (i_memAck) begin
                        word1_q <= i_memData;
                        if (is_direct) begin
                            col1_q      <= i_memData;
                            state_q     <= OUT;
                            mem_req_q   <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else if (mask_q[0]) begin
                            state_q       <= CLUT0;
                            mem_is_clut_q <= 1'b1;
                            mem_addr_q    <= clut_addr(idx0, clut_x_q, clut_y_q);
                        end else begin
                            state_q       <= CLUT1;
                            mem_is_clut_q <= 1'b1;
                            mem_addr_q    <= clut_addr(pal_index(i_memData, fmt_q, u1_q),
                                                       clut_x_q, clut_y_q);
                        end
                    end
                end

                CLUT0: begin
                    if (i_memAck) begin
                        col0_q <= i_memData;
                        if (mask_q[1] && !(MERGE_EN && (idx0 == idx1))) begin
                            state_q    <= CLUT1;
                            mem_addr_q <= clut_addr(idx1, clut_x_q, clut_y_q);
                        end else begin
                            if (mask_q[1]) col1_q <= i_memData;
                            state_q       <= OUT;
                            mem_req_q     <= 1'b0;
                            mem_is_clut_q <= 1'b0;
                            out_valid_q   <= 1'b1;
                        end
                    end
                end

                CLUT1: begin
                    if (i_memAck) begin
                        col1_q        <= i_memData;
                        state_q       <= OUT;
                        mem_req_q     <= 1'b0;
                        mem_is_clut_q <= 1'b0;
                        out_valid_q   <= 1'b1;
                    end
                end

                OUT: begin
                    if (i_outReady) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end

                default: begin
                    state_q       <= IDLE;
                    mem_req_q     <= 1'b0;
                    mem_is_clut_q <= 1'b0;
                    out_valid_q   <= 1'b0;
                    req_ready_q   <= 1'b1;
                end
            endcase
        end
    end

    assign o_reqReady  = req_ready_q;
    assign o_memReq    = mem_req_q;
    assign o_memAddr   = mem_addr_q;
    assign o_memIsClut = mem_is_clut_q;
    assign o_outValid  = out_valid_q;
    assign o_col0      = col0_q;
    assign o_col1      = col1_q;

endmodule
